// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// Takes 32 BUSY cycles per divide and holds F/D/E through stall_div until the {HI, LO} result is ready.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        annul,
    output logic        stall_div,
    output logic        ready,
    output logic [63:0] div_result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT       state;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic [5:0]  cnt;
    logic        qNeg;
    logic        rNeg;
    logic [63:0] divResult;

    logic [31:0] absA, absB;
    logic [32:0] shifted, remNext;
    logic [31:0] quoNext, quoFinal, remFinal;

    assign absA = (signed_div && a[31]) ? (~a + 32'd1) : a;
    assign absB = (signed_div && b[31]) ? (~b + 32'd1) : b;

    // One restoring step. A set rem[32] means the shifted value already exceeds any 32-bit divisor.
    always_comb begin
        shifted = {rem[31:0], quo[31]};
        quoNext = {quo[30:0], 1'b0};
        remNext = shifted;
        if (rem[32] || (shifted >= {1'b0, divisor})) begin
            remNext    = shifted - {1'b0, divisor};
            quoNext[0] = 1'b1;
        end
    end

    assign quoFinal = qNeg ? (~quoNext + 32'd1) : quoNext;
    assign remFinal = rNeg ? (~remNext[31:0] + 32'd1) : remNext[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            cnt       <= '0;
            qNeg      <= 1'b0;
            rNeg      <= 1'b0;
            divResult <= '0;
        end else if (annul) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b == 32'd0) begin
                            // Divide by zero skips the iteration entirely.
                            divResult <= {a, 32'hFFFF_FFFF};
                            state     <= DONE;
                        end else begin
                            rem     <= '0;
                            quo     <= absA;
                            divisor <= absB;
                            qNeg    <= (a[31] ^ b[31]) & signed_div;
                            rNeg    <= a[31] & signed_div;
                            cnt     <= '0;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem <= remNext;
                    quo <= quoNext;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        divResult <= {remFinal, quoFinal};
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_div  = ((state == IDLE) && start && !annul) || (state == BUSY);
    assign ready      = (state == DONE);
    assign div_result = divResult;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, stall window, signed/unsigned results,
// divide-by-zero, annul and reset mid-operation, and operand changes while busy.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        stall_div;
    logic        ready;
    logic [63:0] div_result;

    int tests = 0;
    int fails = 0;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .stall_div  (stall_div),
        .ready      (ready),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues a divide at the current cycle (cycle 0), holds start like a stalled E stage
    // until the DONE cycle, and scrambles the operands mid-operation.
    task automatic runDiv(input string tag, input logic sgn, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp, input int lat);
        int badStall = 0;
        int earlyReady = 0;
        logic readyAt = 1'b0;
        logic [63:0] resAt = '0;
        signed_div = sgn;
        a = av;
        b = bv;
        start = 1'b1;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            if (stall_div !== (c < lat)) badStall++;
            if (c < lat && ready !== 1'b0) earlyReady++;
            if (c == lat) begin
                readyAt = ready;
                resAt   = div_result;
            end
            @(posedge clk);
            #1;
            if (c == 2) begin
                a = ~av;
                b = bv + 32'd5;
                signed_div = ~sgn;
            end
        end
        start = 1'b0;
        chk({tag, "_stall"}, 64'(badStall), 64'd0);
        chk({tag, "_early"}, 64'(earlyReady), 64'd0);
        chk({tag, "_ready"}, 64'(readyAt), 64'd1);
        chk({tag, "_res"}, resAt, exp);
    endtask

    task automatic idleCheck(input string tag, input logic [63:0] exp);
        @(negedge clk);
        chk({tag, "_idle_ready"}, 64'(ready), 64'd0);
        chk({tag, "_idle_stall"}, 64'(stall_div), 64'd0);
        chk({tag, "_hold"}, div_result, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int badS;
        int badR;
        rst = 1'b1;
        start = 1'b0;
        signed_div = 1'b0;
        a = '0;
        b = '0;
        annul = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall", 64'(stall_div), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_result", div_result, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // annul beats start in IDLE
        start = 1'b1; a = 32'd50; b = 32'd5; annul = 1'b1;
        @(negedge clk);
        chk("idle_annul_stall", 64'(stall_div), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0; annul = 1'b0;
        idleCheck("idle_annul", 64'd0);

        runDiv("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        idleCheck("divu_100_7", {32'd2, 32'd14});
        runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        runDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        idleCheck("div_7_m2", {32'h0000_0001, 32'hFFFF_FFFD});
        runDiv("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
        runDiv("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 33);
        runDiv("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 33);
        runDiv("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 33);
        runDiv("divu_zero", 1'b0, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 1);
        idleCheck("divu_zero", {32'h0000_1234, 32'hFFFF_FFFF});

        // annul at cycle 10 of a busy divide, fresh start at cycle 11
        signed_div = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        badS = 0; badR = 0;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) annul = 1'b1;
            @(negedge clk);
            if (ready !== 1'b0) badR++;
            if (stall_div !== 1'b1) badS++;
            @(posedge clk);
            #1;
        end
        annul = 1'b0;
        chk("annul_stall", 64'(badS), 64'd0);
        chk("annul_ready", 64'(badR), 64'd0);
        runDiv("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
        idleCheck("after_annul", {32'd0, 32'd3});

        // synchronous reset at cycle 5 of BUSY
        signed_div = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            if (c == 5) rst = 1'b1;
            @(negedge clk);
            if (c == 5) chk("rst_busy_stall_c5", 64'(stall_div), 64'd1);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_busy_stall", 64'(stall_div), 64'd0);
        chk("rst_busy_ready", 64'(ready), 64'd0);
        chk("rst_busy_result", div_result, 64'd0);
        badR = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready !== 1'b0 || stall_div !== 1'b0) badR++;
        end
        chk("rst_busy_quiet", 64'(badR), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit radix-2 divider for MIPS DIV/DIVU, sitting in the execute stage beside the ALU. The decoded ALU control in E selects it; it holds the pipeline through a stall request to the hazard unit. It returns {HI, LO} alongside the E-stage result so the HI/LO write enable carried to M and W commits it.

## Interface
Parameters:
- None. The datapath is fixed at 32-bit operands and a 64-bit result.

Ports:
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: a DIV/DIVU is present in E. Level signal, held by the stalled E stage.
- `signed_div` in 1: 1 = DIV (two's complement), 0 = DIVU. Sampled with `start`.
- `a` in 32: dividend (rs). Sampled with `start`.
- `b` in 32: divisor (rt). Sampled with `start`.
- `annul` in 1: synchronous cancel, driven by `flushE` or an exception. Aborts any operation in progress.
- `stall_div` out 1: request to the hazard unit to hold F/D/E.
- `ready` out 1: `div_result` is valid this cycle.
- `div_result` out 64: {remainder → HI [63:32], quotient → LO [31:0]}.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `start`=1, `annul`=0, `b`≠0: latch the magnitudes |a| and |b| (plain values when unsigned). Latch the quotient sign (a[31]^b[31]) & `signed_div` and the remainder sign a[31] & `signed_div`. Clear the 6-bit step counter. Go to BUSY.
  - `start`=1, `annul`=0, `b`=0: load quotient = 32'hFFFF_FFFF and remainder = a (raw, no sign handling). Go to DONE.
- BUSY: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - If rem[32:0] ≥ {1'b0, |b|}, subtract |b| and set quo[0].
  - The remainder register is 33 bits.
  - After step 32 (counter 31 → 32), go to DONE.
- DONE: `div_result` holds the sign-corrected quotient and remainder (two's-complement negate where the latched sign is set). Go to IDLE unconditionally next cycle. `start` is ignored in DONE.
- Special case: 0x8000_0000 / 0xFFFF_FFFF signed gives quotient 0x8000_0000, remainder 0. This falls out of the magnitude path with no special logic.
- Operand changes on `a`/`b` after acceptance are ignored.
- `annul` = 1 in any state: go to IDLE next cycle, `ready`=0, no result produced. `annul` beats a simultaneous `start`.
- `rst`: state IDLE, counter 0, all datapath registers 0.

## Timing
- Output equations:
  - `stall_div` = (IDLE & `start` & ~`annul`) | BUSY. Combinational from state and inputs.
  - `ready` = DONE. Registered state decode.
- `div_result` is registered and stable from the DONE cycle until the next accepted `start`.
- Nonzero divisor, `start` first seen in IDLE at cycle 0:
  - BUSY during cycles 1–32.
  - DONE at cycle 33.
  - `stall_div` high cycles 0–32, low at 33.
  - E advances at the end of cycle 33. The next E instruction sees IDLE at cycle 34.
- Zero divisor: `stall_div` high cycle 0 only. DONE at cycle 1.
- Back-to-back divides: the second `start` is accepted the cycle after DONE. No bubble beyond the IDLE entry cycle.
- Reset values: `stall_div`=0 (with `start`=0), `ready`=0, `div_result`=0.
- `rst` or `annul` mid-BUSY: `stall_div` drops the following cycle. Partial results are discarded.

## Test plan
- DIVU 100 / 7, `start` at cycle 0 → `stall_div` high cycles 0–32; `ready` at 33; `div_result` = {32'd2, 32'd14}.
- DIV −7 / 2 (0xFFFF_FFF9 / 2) → `div_result` = {0xFFFF_FFFF, 0xFFFF_FFFD}. DIV 7 / −2 → {0x0000_0001, 0xFFFF_FFFD}.
- DIV 0x8000_0000 / 0xFFFF_FFFF → {0x0000_0000, 0x8000_0000}. DIVU 0xFFFF_FFFF / 1 → {0, 0xFFFF_FFFF}.
- Divisor 0: DIVU 0x1234 / 0 → `ready` at cycle 1, `div_result` = {0x0000_1234, 0xFFFF_FFFF}, `stall_div` high only cycle 0.
- `annul` at cycle 10 of a busy divide → IDLE at 11, `ready` never asserts. New `start` at 11 with 9/3 → `ready` at 44, result {0, 3}.
- `rst` asserted at cycle 5 of BUSY, released at 6 → `ready`/`stall_div` 0 from cycle 6. Change `a`/`b` during BUSY → result unaffected.
